pipelined_add_sub: RTL and testbench
====================================

Name: pipelined_add_sub

Overview:
- Parametrised, carry-pipelined add/subtract unit for the HD accelerator datapath.
- Replaces a flat ripple adder where wide operands would break timing.
- Splits WIDTH into STAGES equal chunks. One chunk is resolved per pipeline stage, and the inter-chunk carry is registered.
- Accepts one operation per cycle under a valid/ready handshake with backpressure, and reports carry-out and signed overflow.

Parameters:
- WIDTH, 32, operand and result width in bits.
- STAGES, 4, number of pipeline stages and chunks. WIDTH % STAGES must be 0, otherwise an elaboration error is raised. CHUNK = WIDTH/STAGES.

Ports:
- i_clk  input  1  clock; all state updates on the rising edge.
- i_rst_n  input  1  asynchronous active-low reset.
- i_valid  input  1  input beat valid.
- o_ready  output  1  unit can accept a beat this cycle.
- i_a  input  WIDTH  operand A.
- i_b  input  WIDTH  operand B.
- i_sub  input  1  0: A+B+i_carry; 1: A-B (A + ~B + 1).
- i_carry  input  1  carry-in for add; ignored when i_sub=1.
- o_valid  output  1  result beat valid.
- i_ready  input  1  downstream accepts the result this cycle.
- o_sum  output  WIDTH  result, modulo 2^WIDTH.
- o_carry  output  1  carry out of the MSB. For subtract, 1 means no borrow (A >= B unsigned).
- o_overflow  output  1  signed two's-complement overflow: the MSB carry-in XOR the MSB carry-out.

Behaviour:
- Reset (i_rst_n low, asynchronous):
  - All stage valid bits, data, carry and skew registers clear to 0.
  - o_valid=0, o_sum=0, o_carry=0, o_overflow=0.
  - o_ready=1 as soon as reset is released.
- Handshake:
  - An input beat is accepted when i_valid && o_ready.
  - An output beat is consumed when o_valid && i_ready.
  - Pipeline advance enable: adv = !o_valid || i_ready.
  - o_ready = adv, which is a global stall.
  - When adv=0, every stage register holds, and o_sum/o_carry/o_overflow are stable.
  - Bubbles are not compressed during a stall.
- Latency: exactly STAGES cycles from acceptance to o_valid when adv stays 1. Throughput is 1 beat per cycle.
- Datapath:
  - At acceptance, B' = i_sub ? ~i_b : i_b and cin = i_sub ? 1 : i_carry.
  - Stage k (0..STAGES-1) adds chunk k of A and B' with the carry registered from stage k-1 (stage 0 uses cin). It registers the CHUNK-bit partial sum and the carry.
  - Upper, not-yet-used operand chunks travel through skew registers.
  - Completed lower sum chunks travel through deskew registers, so all chunks of one beat reach the output in the same cycle.
- Output flags:
  - The final stage also registers the carry into the MSB so overflow = c_in_msb ^ c_out.
- Per-stage control: each stage carries its own valid bit. Stage data registers load only when adv=1. Output registers load only when a valid beat arrives; otherwise they hold the last result.
- STAGES=1: single registered adder with latency 1 and identical handshake.
- Reset mid-operation: in-flight beats are discarded, never emitted after release.
- Simultaneous accept and emit in the same cycle is legal and required for full throughput.

Test Plan:
- WIDTH=8, STAGES=2, add, i_a=10, i_b=8'hF6 (-10), i_carry=0 -> after 2 cycles o_valid=1, o_sum=8'h00, o_carry=1, o_overflow=0.
- WIDTH=8, STAGES=2, add, i_a=65, i_b=66 -> o_sum=8'h83, o_carry=0, o_overflow=1.
- WIDTH=8, i_sub=1, i_a=8'h80, i_b=8'h01 -> o_sum=8'h7F, o_carry=1, o_overflow=1. Also i_a=3, i_b=5 -> o_sum=8'hFE, o_carry=0, o_overflow=0.
- WIDTH=32, STAGES=4:
  - Stream 8 back-to-back beats including 32'hFFFFFFFF + 1 (carry ripples across all 4 chunks) -> o_sum=0, o_carry=1.
  - All 8 results arrive in order, one per cycle, first one 4 cycles after first accept.
  - Check against a reference model.
- Backpressure: with the pipeline full, drop i_ready for 3 cycles -> o_ready=0 for those cycles, o_sum/o_carry/o_overflow unchanged. After i_ready returns, all beats appear exactly once, in order.
- Reset mid-stream: pull i_rst_n low with 3 beats in flight -> o_valid=0 and outputs zero immediately (asynchronously). After release, o_valid stays 0 until new beats are accepted and no stale results appear.

Source files
------------

// File: rtl/pipelined_add_sub_if.sv
// Operand/result bus of the carry-pipelined add/subtract unit.
// The slave side is the arithmetic unit; the master side is whoever feeds it
// operands and takes the results.
interface pipelined_add_sub_if #(
   parameter int WIDTH = 32
);
   // Operand side: upstream -> unit
   logic             i_valid;
   logic             o_ready;
   logic [WIDTH-1:0] i_a;
   logic [WIDTH-1:0] i_b;
   logic             i_sub;
   logic             i_carry;

   // Result side: unit -> downstream
   logic             o_valid;
   logic             i_ready;
   logic [WIDTH-1:0] o_sum;
   logic             o_carry;
   logic             o_overflow;

   modport slave (
      input  i_valid, i_a, i_b, i_sub, i_carry, i_ready,
      output o_ready, o_valid, o_sum, o_carry, o_overflow
   );

   modport master (
      output i_valid, i_a, i_b, i_sub, i_carry, i_ready,
      input  o_ready, o_valid, o_sum, o_carry, o_overflow
   );
endinterface

// File: rtl/pipelined_add_sub.sv
// Carry-pipelined add/subtract unit. WIDTH is cut into STAGES chunks of
// CHUNK bits; stage k adds chunk k with the carry registered by stage k-1.
// Each stage register holds one WIDTH-bit word whose low chunks are finished
// sum bits and whose high chunks are still-unused A bits, so the A skew and
// the sum deskew share one register. Unused B chunks ride along in a
// separate, shrinking skew register. A single advance enable stalls the
// whole pipe when the output is held by downstream backpressure.
module pipelined_add_sub #(
   parameter int WIDTH  = 32,
   parameter int STAGES = 4
) (
   input  logic               i_clk,
   input  logic               i_rst_n,
   pipelined_add_sub_if.slave bus
);

   localparam int CHUNK = WIDTH / STAGES;

   if (STAGES < 1 || (WIDTH % STAGES) != 0) begin : g_cfg_check
      $error("pipelined_add_sub: WIDTH (%0d) must be a multiple of STAGES (%0d)",
             WIDTH, STAGES);
   end

   logic             adv;
   logic [WIDTH-1:0] b_eff;
   logic             cin;

   // Subtract is A + ~B + 1; i_carry only matters for add.
   assign b_eff = bus.i_sub ? ~bus.i_b : bus.i_b;
   assign cin   = bus.i_sub ? 1'b1 : bus.i_carry;

   for (genvar k = 0; k < STAGES; k++) begin : g_stage
      localparam int LO  = k * CHUNK;   // lowest bit resolved by this stage
      localparam int REM = WIDTH - LO;  // B bits still unused on entry

      logic             v_in;
      logic             c_in;
      logic [WIDTH-1:0] word_in;
      logic [REM-1:0]   b_in;
      logic [CHUNK:0]   part;
      logic [WIDTH-1:0] word_nxt;

      logic             v_q;
      logic             c_q;
      logic [WIDTH-1:0] word_q;

      if (k == 0) begin : g_src
         assign v_in    = bus.i_valid;
         assign c_in    = cin;
         assign word_in = bus.i_a;
         assign b_in    = b_eff;
      end else begin : g_src
         assign v_in    = g_stage[k-1].v_q;
         assign c_in    = g_stage[k-1].c_q;
         assign word_in = g_stage[k-1].word_q;
         assign b_in    = g_stage[k-1].g_mid.b_q;
      end

      // Resolve chunk k and splice it into the travelling word.
      always_comb begin
         // NOTE: every always_comb output gets a full default first, so no path leaves it unassigned (no latch).
         word_nxt = word_in;
         part     = {1'b0, word_in[LO +: CHUNK]} + {1'b0, b_in[CHUNK-1:0]}
                  + {{CHUNK{1'b0}}, c_in};
         word_nxt[LO +: CHUNK] = part[CHUNK-1:0];
      end

      if (k < STAGES - 1) begin : g_mid
         logic [REM-CHUNK-1:0] b_q;

         // Inner stage: move valid, chunk carry, word and remaining B on every advance.
         always_ff @(posedge i_clk or negedge i_rst_n) begin
            // NOTE: data registers are reset as well, so nothing stale can leak out after a reset.
            if (!i_rst_n) begin
               v_q    <= 1'b0;
               c_q    <= 1'b0;
               word_q <= '0;
               b_q    <= '0;
            end else if (adv) begin
               // NOTE: state uses <= so each stage samples its neighbour's pre-edge value.
               v_q    <= v_in;
               c_q    <= part[CHUNK];
               word_q <= word_nxt;
               b_q    <= b_in[REM-1:CHUNK];
            end
         end
      end else begin : g_last
         logic cmsb_q;

         // Output stage: valid follows the pipe, result and flags load only on a valid beat.
         always_ff @(posedge i_clk or negedge i_rst_n) begin
            if (!i_rst_n) begin
               v_q    <= 1'b0;
               c_q    <= 1'b0;
               word_q <= '0;
               cmsb_q <= 1'b0;
            end else if (adv) begin
               v_q <= v_in;
               if (v_in) begin
                  c_q    <= part[CHUNK];
                  word_q <= word_nxt;
                  // Sum MSB = a ^ b ^ carry-in, so the carry into the MSB falls out without a second adder.
                  cmsb_q <= word_nxt[WIDTH-1] ^ word_in[WIDTH-1] ^ b_in[CHUNK-1];
               end
            end
         end
      end
   end

   // Global stall: the pipe moves only if the output slot is empty or being drained.
   assign adv            = !g_stage[STAGES-1].v_q || bus.i_ready;
   assign bus.o_ready    = adv;
   assign bus.o_valid    = g_stage[STAGES-1].v_q;
   assign bus.o_sum      = g_stage[STAGES-1].word_q;
   assign bus.o_carry    = g_stage[STAGES-1].c_q;
   assign bus.o_overflow = g_stage[STAGES-1].g_last.cmsb_q ^ g_stage[STAGES-1].c_q;

endmodule

// File: tb/tb_pipelined_add_sub.sv
// Bench for pipelined_add_sub: an 8-bit/2-stage unit for single directed
// operations and a 32-bit/4-stage unit for streaming, backpressure and
// mid-stream reset.
module tb_pipelined_add_sub;

   logic clk = 1'b0;
   logic rst_n;
   int   n_tests = 0;
   int   n_fail  = 0;

   always #5 clk = ~clk;

   pipelined_add_sub_if #(.WIDTH(8))  bus8  ();
   pipelined_add_sub_if #(.WIDTH(32)) bus32 ();

   pipelined_add_sub #(.WIDTH(8), .STAGES(2)) u_dut8 (
      .i_clk   (clk),
      .i_rst_n (rst_n),
      .bus     (bus8)
   );

   pipelined_add_sub #(.WIDTH(32), .STAGES(4)) u_dut32 (
      .i_clk   (clk),
      .i_rst_n (rst_n),
      .bus     (bus32)
   );

   // 32-bit beat table: 0-7 stream, 8-13 backpressure, 14-15 after reset
   logic [31:0] t_a   [16];
   logic [31:0] t_b   [16];
   logic        t_sub [16];
   logic        t_cin [16];

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask

   // Reference: {overflow, carry, sum} from plain 33-bit arithmetic
   function automatic logic [33:0] model(input logic [31:0] a, input logic [31:0] b,
                                         input logic sub, input logic cin);
      logic [31:0] bb;
      logic [32:0] r;
      logic        ov;
      bb = sub ? ~b : b;
      r  = {1'b0, a} + {1'b0, bb} + {32'd0, (sub ? 1'b1 : cin)};
      ov = (a[31] == bb[31]) && (r[31] != a[31]);
      return {ov, r};
   endfunction

   // One 8-bit operation: checks ready, the 2-cycle latency and the result.
   task automatic op8(input string tag, input logic [7:0] a, input logic [7:0] b,
                      input logic sub, input logic cin,
                      input logic [7:0] e_sum, input logic e_c, input logic e_ov);
      @(negedge clk);
      bus8.i_a = a; bus8.i_b = b; bus8.i_sub = sub; bus8.i_carry = cin;
      bus8.i_valid = 1'b1;
      #1 check({tag, " ready"}, bus8.o_ready, 1);
      @(negedge clk);
      bus8.i_valid = 1'b0;
      #1 check({tag, " early"}, bus8.o_valid, 0);
      @(negedge clk);
      #1;
      check({tag, " valid"}, bus8.o_valid, 1);
      check({tag, " sum"},   bus8.o_sum, e_sum);
      check({tag, " carry"}, bus8.o_carry, e_c);
      check({tag, " ovf"},   bus8.o_overflow, e_ov);
   endtask

   // Stream n beats from the table into the 32-bit unit, dropping i_ready for
   // stall_len cycles starting at cycle stall_at. Results are scoreboarded in order.
   task automatic run_stream(input int first, input int n, input int stall_at,
                             input int stall_len, input string tag);
      int          sent = 0;
      int          got = 0;
      int          t_acc = -1;
      int          t_out = -1;
      int          t_last = -1;
      bit          p_stall = 1'b0;
      logic [31:0] p_sum = '0;
      logic        p_c = 1'b0;
      logic        p_ov = 1'b0;
      logic [33:0] exp;
      for (int t = 0; t < 60 && got < n; t++) begin
         @(negedge clk);
         bus32.i_ready = !(t >= stall_at && t < stall_at + stall_len);
         if (sent < n) begin
            bus32.i_a     = t_a[first+sent];
            bus32.i_b     = t_b[first+sent];
            bus32.i_sub   = t_sub[first+sent];
            bus32.i_carry = t_cin[first+sent];
            bus32.i_valid = 1'b1;
         end else begin
            bus32.i_valid = 1'b0;
         end
         #1;
         if (p_stall) begin
            check({tag, " hold sum"},   bus32.o_sum, p_sum);
            check({tag, " hold carry"}, bus32.o_carry, p_c);
            check({tag, " hold ovf"},   bus32.o_overflow, p_ov);
         end
         if (bus32.o_valid && !bus32.i_ready)
            check({tag, " stall ready"}, bus32.o_ready, 0);
         if (bus32.o_valid && bus32.i_ready) begin
            exp = model(t_a[first+got], t_b[first+got], t_sub[first+got], t_cin[first+got]);
            check($sformatf("%s sum[%0d]", tag, got),   bus32.o_sum, exp[31:0]);
            check($sformatf("%s carry[%0d]", tag, got), bus32.o_carry, exp[32]);
            check($sformatf("%s ovf[%0d]", tag, got),   bus32.o_overflow, exp[33]);
            if (t_out < 0) t_out = t;
            t_last = t;
            got++;
         end
         if (bus32.i_valid && bus32.o_ready) begin
            if (t_acc < 0) t_acc = t;
            sent++;
         end
         p_stall = bus32.o_valid && !bus32.i_ready;
         p_sum   = bus32.o_sum;
         p_c     = bus32.o_carry;
         p_ov    = bus32.o_overflow;
      end
      bus32.i_valid = 1'b0;
      bus32.i_ready = 1'b1;
      check({tag, " count"}, got, n);
      if (stall_len == 0) begin
         check({tag, " latency"}, t_out - t_acc, 4);
         check({tag, " b2b"}, t_last - t_out, n - 1);
      end
      @(negedge clk);
      #1 check({tag, " drained"}, bus32.o_valid, 0);
   endtask

   // Reset with three beats in flight: outputs clear at once, nothing stale afterwards.
   task automatic reset_mid_stream();
      int seen = 0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         bus32.i_a = t_a[i]; bus32.i_b = t_b[i];
         bus32.i_sub = t_sub[i]; bus32.i_carry = t_cin[i];
         bus32.i_valid = 1'b1;
      end
      @(negedge clk);
      bus32.i_valid = 1'b0;
      #1 check("pre_rst sum", bus32.o_sum, 32'h2000_0000);
      #1 rst_n = 1'b0;
      #1;
      check("rst valid", bus32.o_valid, 0);
      check("rst sum",   bus32.o_sum, 0);
      check("rst carry", bus32.o_carry, 0);
      check("rst ovf",   bus32.o_overflow, 0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      #1 check("rst release ready", bus32.o_ready, 1);
      repeat (8) begin
         @(negedge clk);
         #1 if (bus32.o_valid) seen++;
      end
      check("rst stale beats", seen, 0);
   endtask

   initial begin
      t_a   = '{32'hFFFF_FFFF, 32'h7FFF_FFFF, 32'h0000_0000, 32'h1234_5678,
                32'h8000_0000, 32'h0000_FFFF, 32'hDEAD_BEEF, 32'hFFFF_FFFF,
                32'h0000_0001, 32'h1111_1111, 32'hF000_0000, 32'h00FF_00FF,
                32'h4000_0000, 32'h9000_0000, 32'h0000_0005, 32'hCAFE_BABE};
      t_b   = '{32'h0000_0001, 32'h0000_0001, 32'h0000_0001, 32'h8765_4321,
                32'h0000_0001, 32'h0000_0001, 32'hDEAD_BEEF, 32'hFFFF_FFFF,
                32'h0000_0002, 32'h2222_2222, 32'h1000_0000, 32'hFF00_FF00,
                32'h4000_0000, 32'h9000_0000, 32'h0000_0007, 32'h0101_0101};
      t_sub = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0,
                1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
      t_cin = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1,
                1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};

      rst_n = 1'b0;
      bus8.i_valid = 1'b0;  bus8.i_a = '0;  bus8.i_b = '0;
      bus8.i_sub = 1'b0;    bus8.i_carry = 1'b0;  bus8.i_ready = 1'b1;
      bus32.i_valid = 1'b0; bus32.i_a = '0; bus32.i_b = '0;
      bus32.i_sub = 1'b0;   bus32.i_carry = 1'b0; bus32.i_ready = 1'b1;

      repeat (3) @(negedge clk);
      #1;
      check("reset valid8",  bus8.o_valid, 0);
      check("reset sum8",    bus8.o_sum, 0);
      check("reset carry8",  bus8.o_carry, 0);
      check("reset ovf8",    bus8.o_overflow, 0);
      check("reset valid32", bus32.o_valid, 0);
      check("reset sum32",   bus32.o_sum, 0);
      rst_n = 1'b1;
      #1;
      check("reset ready8",  bus8.o_ready, 1);
      check("reset ready32", bus32.o_ready, 1);

      // 8-bit directed vectors, expected values worked out by hand
      op8("add 10-10",   8'd10,   8'hF6, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
      op8("add 65+66",   8'd65,   8'd66, 1'b0, 1'b0, 8'h83, 1'b0, 1'b1);
      op8("sub 80-01",   8'h80,   8'h01, 1'b1, 1'b0, 8'h7F, 1'b1, 1'b1);
      op8("sub 3-5",     8'd3,    8'd5,  1'b1, 1'b0, 8'hFE, 1'b0, 1'b0);
      op8("add 0F+cin",  8'h0F,   8'h00, 1'b0, 1'b1, 8'h10, 1'b0, 1'b0);
      op8("sub 5-5",     8'd5,    8'd5,  1'b1, 1'b0, 8'h00, 1'b1, 1'b0);
      op8("add FF+1+c",  8'hFF,   8'h01, 1'b0, 1'b1, 8'h01, 1'b1, 1'b0);

      run_stream(0, 8, 0, 0, "stream");
      run_stream(8, 6, 6, 3, "bp");
      reset_mid_stream();
      run_stream(14, 2, 0, 0, "post_rst");

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
